renamed_register_file: RTL and testbench
========================================

// Module: renamed_register_file
// PURPOSE
//  Architectural register file with per-register ROB rename tags, N_READ read ports, fully synchronous update.
//  Sits between the instruction unit (renames a destination at dispatch, reads sources) and the reorder buffer
//  (commits values, forwards ready ROB results). Tracks the count of renamed registers for stall/debug use.
// PARAMETERS
//  ROB_WIDTH  4   bits of a ROB entry id
//  NUM_REGS   32  architectural registers; index 0 is hardwired to zero
//  REG_AW     5   register index width, clog2(NUM_REGS)
//  N_READ     2   read ports; port p occupies slice [p*W +: W] of every packed bus below
// PORTS
//  clockIn         in   1                  clock
//  resetIn         in   1                  async reset, active-high
//  clearIn         in   1                  pipeline flush (sync)
//  rdAddr          in   N_READ*REG_AW      source register index per port
//  rfUpdateValid   in   1                  dispatch renames rfUpdateDest
//  rfUpdateDest    in   REG_AW             renamed destination
//  rfUpdateRobId   in   ROB_WIDTH          ROB id now owning rfUpdateDest
//  regUpdateValid  in   1                  ROB commit
//  regUpdateDest   in   REG_AW             committed destination
//  regUpdateValue  in   32                 committed value
//  regUpdateRobId  in   ROB_WIDTH          committing ROB id
//  robDep          out  N_READ*ROB_WIDTH   tag per port, sent to ROB lookup
//  robReady        in   N_READ             ROB result for robDep is ready
//  robValue        in   N_READ*32          ROB result for robDep
//  rsDirty         out  N_READ             operand still pending
//  rsDependency    out  N_READ*ROB_WIDTH   tag to wait on (equals robDep)
//  rsValue         out  N_READ*32          operand value
//  pendingCount    out  REG_AW+1           registers currently holding a rename tag
// BEHAVIOUR
//  - Async reset: all registers 0, tags 0, busy bits 0, rdAddr latches 0, pendingCount 0; outputs show reg 0 clean, value 0.
//  - rdAddr sampled at posedge; port outputs are combinational from latched index plus current state (1-cycle latency).
//  - rsDirty = busy[idx] & ~robReady; rsValue = busy[idx] ? robValue : regs[idx]; idx 0 always clean, value 0.
//  - All state updates on posedge only; no latches.
//  - Rename (rfUpdateValid, dest!=0, !clearIn): tag[dest]<=rfUpdateRobId, busy[dest]<=1 (overwrites older tag).
//  - Commit (regUpdateValid, dest!=0): regs[dest]<=value; busy[dest]<=0 only if tag[dest]==regUpdateRobId.
//  - Rename+commit same dest same cycle: value written, rename wins (busy=1, new tag).
//  - Read of a reg being committed/renamed in the same cycle sees pre-edge state (no bypass unless macro set).
//  - clearIn: all busy<=0, tags kept, pending rename dropped; a same-cycle commit still writes its value.
//  - pendingCount = popcount(busy), maintained incrementally: +1 on rename of a non-busy reg, -1 on tag-matched
//    clear, net 0 when both hit; forced 0 on clearIn. Never exceeds NUM_REGS-1; must equal popcount at all times.
// CONFIGURATION
//  RF_COMMIT_BYPASS_EN defined: a port whose sampled index equals a same-cycle rdAddr of regUpdateDest commit is
//    marked so that the next-cycle output reflects the commit (already true since state updates); additionally,
//    combinational forwarding: if regUpdateValid and regUpdateDest==latched idx (!=0) and regUpdateRobId==tag,
//    rsDirty=0 and rsValue=regUpdateValue in the same cycle.
//  Undefined: no forwarding; commit visible on the cycle after the edge.
// TESTING
//  1 Reset mid-run with busy regs -> all rsDirty 0, rsValue 0, pendingCount 0 immediately (async).
//  2 Rename x5->rob 3; read x5 next cycle, robReady=0 -> rsDirty=1, rsDependency=3, pendingCount=1.
//  3 Same, robReady=1 robValue=0xDEAD -> rsDirty=0, rsValue=0xDEAD; commit x5 rob3 0xDEAD -> busy clear, count 0.
//  4 Rename x7 rob2, rename x7 rob6, commit x7 rob2 val 9 -> regs[x7]=9, still busy tag 6, count 1.
//  5 Same-cycle rename x4 rob1 + commit x4 (tag match) -> busy=1 tag1, value written, count unchanged.
//  6 Three regs busy, clearIn with commit x3 val 0x55 -> all clean, count 0, x3 reads 0x55; writes to x0 ignored.

Source files
------------

// File: rtl/renamed_register_file.sv
// Architectural register file with per-register ROB rename tags and N_READ read ports.
// Optional macro RF_COMMIT_BYPASS_EN: same-cycle commit forwarding onto read ports.
module renamed_register_file #(
  parameter int ROB_WIDTH = 4,
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int N_READ    = 2
) (
  input  logic                          clockIn,
  input  logic                          resetIn,
  input  logic                          clearIn,
  input  logic [N_READ*REG_AW-1:0]      rdAddr,
  input  logic                          rfUpdateValid,
  input  logic [REG_AW-1:0]             rfUpdateDest,
  input  logic [ROB_WIDTH-1:0]          rfUpdateRobId,
  input  logic                          regUpdateValid,
  input  logic [REG_AW-1:0]             regUpdateDest,
  input  logic [31:0]                   regUpdateValue,
  input  logic [ROB_WIDTH-1:0]          regUpdateRobId,
  output logic [N_READ*ROB_WIDTH-1:0]   robDep,
  input  logic [N_READ-1:0]             robReady,
  input  logic [N_READ*32-1:0]          robValue,
  output logic [N_READ-1:0]             rsDirty,
  output logic [N_READ*ROB_WIDTH-1:0]   rsDependency,
  output logic [N_READ*32-1:0]          rsValue,
  output logic [REG_AW:0]               pendingCount
);

  logic [31:0]          regs   [NUM_REGS];
  logic [ROB_WIDTH-1:0] tags   [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic [REG_AW-1:0]    rd_idx [N_READ];
  logic [REG_AW:0]      count;

  logic rename_en;
  logic commit_en;
  logic commit_clr;
  logic count_inc;
  logic count_dec;

  // Decode this cycle's rename/commit effects and the busy-count delta.
  always_comb begin
    rename_en  = rfUpdateValid && (rfUpdateDest != '0) && !clearIn;
    commit_en  = regUpdateValid && (regUpdateDest != '0);
    commit_clr = commit_en && (tags[regUpdateDest] == regUpdateRobId);
    count_inc  = rename_en && !busy[rfUpdateDest];
    count_dec  = commit_clr && busy[regUpdateDest]
                 && !(rename_en && (rfUpdateDest == regUpdateDest));
  end

  // Register, tag, busy, read-index and pending-count state.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      for (int p = 0; p < N_READ; p++) begin
        rd_idx[p] <= '0;
      end
      busy  <= '0;
      count <= '0;
    end else begin
      for (int p = 0; p < N_READ; p++) begin
        rd_idx[p] <= rdAddr[p*REG_AW +: REG_AW];
      end
      if (commit_en) begin
        regs[regUpdateDest] <= regUpdateValue;
      end
      if (clearIn) begin
        busy  <= '0;
        count <= '0;
      end else begin
        if (commit_clr) begin
          busy[regUpdateDest] <= 1'b0;
        end
        if (rename_en) begin
          busy[rfUpdateDest] <= 1'b1;
          tags[rfUpdateDest] <= rfUpdateRobId;
        end
        unique case ({count_inc, count_dec})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Per-port operand lookup from latched index and current state.
  always_comb begin
    robDep       = '0;
    rsDirty      = '0;
    rsDependency = '0;
    rsValue      = '0;
    for (int p = 0; p < N_READ; p++) begin
      robDep[p*ROB_WIDTH +: ROB_WIDTH]       = tags[rd_idx[p]];
      rsDependency[p*ROB_WIDTH +: ROB_WIDTH] = tags[rd_idx[p]];
      if (rd_idx[p] != '0) begin
        rsDirty[p] = busy[rd_idx[p]] & ~robReady[p];
        rsValue[p*32 +: 32] = busy[rd_idx[p]] ? robValue[p*32 +: 32]
                                               : regs[rd_idx[p]];
`ifdef RF_COMMIT_BYPASS_EN
        if (regUpdateValid && (regUpdateDest == rd_idx[p])
            && (regUpdateRobId == tags[rd_idx[p]])) begin
          rsDirty[p]          = 1'b0;
          rsValue[p*32 +: 32] = regUpdateValue;
        end
`else
`endif
      end
    end
  end

  assign pendingCount = count;

endmodule

// File: tb/tb_renamed_register_file.sv
// Directed scoreboard bench for renamed_register_file.
// Expectations queued with stimulus, drained after each edge.
module tb_renamed_register_file;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        clearIn;
  logic [9:0]  rdAddr;
  logic        rfUpdateValid;
  logic [4:0]  rfUpdateDest;
  logic [3:0]  rfUpdateRobId;
  logic        regUpdateValid;
  logic [4:0]  regUpdateDest;
  logic [31:0] regUpdateValue;
  logic [3:0]  regUpdateRobId;
  logic [7:0]  robDep;
  logic [1:0]  robReady;
  logic [63:0] robValue;
  logic [1:0]  rsDirty;
  logic [7:0]  rsDependency;
  logic [63:0] rsValue;
  logic [5:0]  pendingCount;

  renamed_register_file dut (
    .clockIn        (clockIn),
    .resetIn        (resetIn),
    .clearIn        (clearIn),
    .rdAddr         (rdAddr),
    .rfUpdateValid  (rfUpdateValid),
    .rfUpdateDest   (rfUpdateDest),
    .rfUpdateRobId  (rfUpdateRobId),
    .regUpdateValid (regUpdateValid),
    .regUpdateDest  (regUpdateDest),
    .regUpdateValue (regUpdateValue),
    .regUpdateRobId (regUpdateRobId),
    .robDep         (robDep),
    .robReady       (robReady),
    .robValue       (robValue),
    .rsDirty        (rsDirty),
    .rsDependency   (rsDependency),
    .rsValue        (rsValue),
    .pendingCount   (pendingCount)
  );

  always #5 clockIn = ~clockIn;

  localparam int K_DIRTY = 0;
  localparam int K_DEP   = 1;
  localparam int K_VAL   = 2;
  localparam int K_CNT   = 3;
  localparam int K_RDEP  = 4;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string n, input int k, input int p,
                      input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.kind = k;
    x.port = p;
    x.exp  = e;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] obs(input int k, input int p);
    logic [31:0] o;
    o = '0;
    case (k)
      K_DIRTY: o = {31'd0, rsDirty[p]};
      K_DEP:   o = {28'd0, rsDependency[p*4 +: 4]};
      K_VAL:   o = rsValue[p*32 +: 32];
      K_CNT:   o = {26'd0, pendingCount};
      default: o = {28'd0, robDep[p*4 +: 4]};
    endcase
    return o;
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.kind, e.port);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clockIn);
    #1;
    rfUpdateValid  = 1'b0;
    regUpdateValid = 1'b0;
    clearIn        = 1'b0;
  endtask

  task automatic rename(input logic [4:0] d, input logic [3:0] id);
    rfUpdateValid = 1'b1;
    rfUpdateDest  = d;
    rfUpdateRobId = id;
  endtask

  task automatic commit(input logic [4:0] d, input logic [31:0] v,
                        input logic [3:0] id);
    regUpdateValid = 1'b1;
    regUpdateDest  = d;
    regUpdateValue = v;
    regUpdateRobId = id;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rdAddr = {a1, a0};
  endtask

  initial begin
    resetIn        = 1'b1;
    clearIn        = 1'b0;
    rdAddr         = '0;
    rfUpdateValid  = 1'b0;
    rfUpdateDest   = '0;
    rfUpdateRobId  = '0;
    regUpdateValid = 1'b0;
    regUpdateDest  = '0;
    regUpdateValue = '0;
    regUpdateRobId = '0;
    robReady       = '0;
    robValue       = '0;
    #1;
    push("rst_cnt", K_CNT, 0, 32'd0);
    push("rst_dirty0", K_DIRTY, 0, 32'd0);
    push("rst_val0", K_VAL, 0, 32'd0);
    push("rst_val1", K_VAL, 1, 32'd0);
    drain();
    repeat (2) @(posedge clockIn);
    #1;
    resetIn = 1'b0;

    // rename x5 -> rob 3, read next cycle
    rename(5'd5, 4'd3);
    set_rd(5'd5, 5'd0);
    cyc();
    push("t2_dirty", K_DIRTY, 0, 32'd1);
    push("t2_dep", K_DEP, 0, 32'd3);
    push("t2_robdep", K_RDEP, 0, 32'd3);
    push("t2_cnt", K_CNT, 0, 32'd1);
    drain();

    // ROB ready forwards value, then commit clears busy
    robReady = 2'b01;
    robValue = {32'h0, 32'h0000_DEAD};
    #1;
    push("t3_fwd_dirty", K_DIRTY, 0, 32'd0);
    push("t3_fwd_val", K_VAL, 0, 32'h0000_DEAD);
    drain();
    robReady = 2'b00;
    robValue = '0;
    commit(5'd5, 32'h0000_DEAD, 4'd3);
    cyc();
    push("t3_cm_dirty", K_DIRTY, 0, 32'd0);
    push("t3_cm_val", K_VAL, 0, 32'h0000_DEAD);
    push("t3_cm_cnt", K_CNT, 0, 32'd0);
    drain();

    // double rename, stale commit keeps newer tag
    rename(5'd7, 4'd2);
    cyc();
    rename(5'd7, 4'd6);
    cyc();
    push("t4_rr_cnt", K_CNT, 0, 32'd1);
    drain();
    commit(5'd7, 32'd9, 4'd2);
    set_rd(5'd0, 5'd7);
    cyc();
    push("t4_dirty", K_DIRTY, 1, 32'd1);
    push("t4_dep", K_DEP, 1, 32'd6);
    push("t4_cnt", K_CNT, 0, 32'd1);
    drain();
    clearIn = 1'b1;
    cyc();
    push("t4_clr_dirty", K_DIRTY, 1, 32'd0);
    push("t4_clr_val", K_VAL, 1, 32'd9);
    push("t4_clr_dep", K_DEP, 1, 32'd6);
    push("t4_clr_cnt", K_CNT, 0, 32'd0);
    drain();

    // same-cycle rename + matching commit on x4
    rename(5'd4, 4'd1);
    set_rd(5'd4, 5'd0);
    cyc();
    push("t5_cnt1", K_CNT, 0, 32'd1);
    drain();
    rename(5'd4, 4'd1);
    commit(5'd4, 32'h44, 4'd1);
    cyc();
    push("t5_dirty", K_DIRTY, 0, 32'd1);
    push("t5_dep", K_DEP, 0, 32'd1);
    push("t5_cnt", K_CNT, 0, 32'd1);
    drain();
    clearIn = 1'b1;
    cyc();
    push("t5_val", K_VAL, 0, 32'h44);
    push("t5_clr_cnt", K_CNT, 0, 32'd0);
    drain();

    // three busy, flush with same-cycle commit and dropped rename
    rename(5'd1, 4'd1);
    cyc();
    rename(5'd2, 4'd2);
    cyc();
    rename(5'd3, 4'd3);
    cyc();
    push("t6_cnt3", K_CNT, 0, 32'd3);
    drain();
    clearIn = 1'b1;
    commit(5'd3, 32'h55, 4'd3);
    rename(5'd9, 4'd7);
    set_rd(5'd3, 5'd9);
    cyc();
    push("t6_dirty0", K_DIRTY, 0, 32'd0);
    push("t6_dirty1", K_DIRTY, 1, 32'd0);
    push("t6_val0", K_VAL, 0, 32'h55);
    push("t6_val1", K_VAL, 1, 32'd0);
    push("t6_dep1", K_DEP, 1, 32'd0);
    push("t6_cnt", K_CNT, 0, 32'd0);
    drain();

    // x0 is hardwired
    rename(5'd0, 4'd5);
    commit(5'd0, 32'hFFFF, 4'd5);
    set_rd(5'd0, 5'd0);
    cyc();
    push("x0_dirty", K_DIRTY, 0, 32'd0);
    push("x0_val", K_VAL, 0, 32'd0);
    push("x0_dep", K_DEP, 0, 32'd0);
    push("x0_cnt", K_CNT, 0, 32'd0);
    drain();

    // async reset mid-run with a busy register
    rename(5'd6, 4'd4);
    set_rd(5'd0, 5'd6);
    cyc();
    push("t1_pre_cnt", K_CNT, 0, 32'd1);
    push("t1_pre_dirty", K_DIRTY, 1, 32'd1);
    drain();
    resetIn = 1'b1;
    #1;
    push("t1_cnt", K_CNT, 0, 32'd0);
    push("t1_dirty", K_DIRTY, 1, 32'd0);
    push("t1_val", K_VAL, 1, 32'd0);
    push("t1_dep", K_DEP, 1, 32'd0);
    drain();
    @(negedge clockIn);
    resetIn = 1'b0;
    cyc();
    push("t1_post_dirty", K_DIRTY, 1, 32'd0);
    push("t1_post_cnt", K_CNT, 0, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
